// File: rtl/mips_pkg.sv
// Shared MIPS fetch constants: widths, reset PC, opcode/funct encodings and the
// legality helper used by the optional IFU_ILLEGAL_OP_EN opcode check.
package mips_pkg;
    localparam int          PC_W     = 32;
    localparam int          INSTR_W  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic is_illegal(input logic [5:0] op, input logic [5:0] fn);
        logic ill;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ill = 1'b0;
                    default:                               ill = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ill = 1'b0;
            default:                             ill = 1'b1;
        endcase
        return ill;
    endfunction
endpackage

// File: rtl/ifu_fifo.sv
// Fetch buffer: DEPTH-entry synchronous FIFO of {instr, pc} with flush.
// Flush wins over a same-cycle push or pop.
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == {CNT_W{1'b0}});
    assign count = count_q;

    ifu_fifo_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush), .count(count_q)
    );
endmodule

// File: rtl/ifu_fifo_chk.sv
// Checker for ifu_fifo: a push into a full buffer that is not relieved by a
// same-cycle pop or flush means the fetch credit logic is broken.
module ifu_fifo_chk #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input logic             clk,
    input logic             rst_n,
    input logic             push,
    input logic             pop,
    input logic             flush,
    input logic [CNT_W-1:0] count
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && (count == CNT_W'(DEPTH))));
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited in-order imem requests, response buffering and
// redirect flush with wrong-path discard. Optional IFU_ILLEGAL_OP_EN adds illegal_op.
module instr_fetch_unit #(
    parameter int              PC_W     = mips_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(mips_pkg::RESET_PC),
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic [5:0]      opcode,
    output logic [5:0]      funct,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc
`ifdef IFU_ILLEGAL_OP_EN
    ,
    output logic            illegal_op
`endif
);
    import mips_pkg::*;

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = INSTR_W + PC_W;

    logic [PC_W-1:0]    pc_q, pc_d, rsp_pc_q, rsp_pc_d, stale_addr_q, stale_addr_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d, discard_q, discard_d;
    logic               stale_q, stale_d, pending_q, pending_d, started_q;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [ENTRY_W-1:0] head_s;
    logic [CNT_W:0]     used_s, limit_s;
    logic               fifo_empty_s, pop_s, credit_s, accept_s, drop_s, push_s;

    assign pop_s    = !fifo_empty_s && instr_ready;
    // A same-cycle pop frees its slot before any new response can land, which keeps 1 instr/cycle at DEPTH=2.
    assign used_s   = {1'b0, outstanding_q} + {1'b0, fifo_count_s};
    assign limit_s  = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop_s);
    assign credit_s = (used_s < limit_s);

    assign imem_req_valid = started_q && (pending_q || credit_s);
    assign imem_req_addr  = stale_q ? stale_addr_q : pc_q;
    assign accept_s       = imem_req_valid && imem_req_ready;
    assign drop_s         = imem_rsp_valid && (discard_q != {CNT_W{1'b0}});
    assign push_s         = imem_rsp_valid && !drop_s && !redirect;

    // Next-state for PCs, in-flight/discard counters and stale-request tracking
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        stale_d       = stale_q;
        stale_addr_d  = stale_addr_q;
        pending_d     = imem_req_valid && !imem_req_ready;
        outstanding_d = outstanding_q + CNT_W'(accept_s) - CNT_W'(imem_rsp_valid);
        discard_d     = discard_q;
        if (redirect) begin
            pc_d      = redirect_pc & ~PC_W'(3);
            rsp_pc_d  = redirect_pc & ~PC_W'(3);
            discard_d = outstanding_d;
            if (pending_d) begin
                stale_d      = 1'b1;
                stale_addr_d = imem_req_addr;
            end else begin
                stale_d = 1'b0;
            end
        end else begin
            if (accept_s && stale_q) begin
                stale_d = 1'b0;
            end else if (accept_s) begin
                pc_d = pc_q + PC_W'(4);
            end else begin
                pc_d = pc_q;
            end
            discard_d = discard_q + CNT_W'(accept_s && stale_q) - CNT_W'(drop_s);
            if (push_s) begin
                rsp_pc_d = rsp_pc_q + PC_W'(4);
            end else begin
                rsp_pc_d = rsp_pc_q;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            stale_addr_q  <= {PC_W{1'b0}};
            outstanding_q <= {CNT_W{1'b0}};
            discard_q     <= {CNT_W{1'b0}};
            stale_q       <= 1'b0;
            pending_q     <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            stale_addr_q  <= stale_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            stale_q       <= stale_d;
            pending_q     <= pending_d;
            started_q     <= 1'b1;
        end
    end

    ifu_fifo #(.DEPTH(DEPTH), .W(ENTRY_W), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect),
        .wdata ({imem_rsp_data, rsp_pc_q}),
        .rdata (head_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign instr_valid = !fifo_empty_s;
    assign instr       = head_s[ENTRY_W-1:PC_W];
    assign instr_pc    = head_s[PC_W-1:0];
    assign opcode      = head_s[ENTRY_W-1:ENTRY_W-6];
    assign funct       = head_s[PC_W+5:PC_W];

`ifdef IFU_ILLEGAL_OP_EN
    assign illegal_op = instr_valid && is_illegal(opcode, funct);
`endif
endmodule
